hazard_forward_ctrl: RTL and testbench

//  Parametrised forwarding + hazard controller for the 5-stage pipeline.

---
 rtl/hazard_forward_ctrl.sv | 144 ++++++++++++++
 tb/tb_hazard_forward_ctrl.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/hazard_forward_ctrl.sv
// Forwarding-select and load-use hazard controller for a 5-stage pipeline.
// EX operand selects favour MEM over WB; load-use hazards stall for LOAD_LAT cycles.
module hazard_forward_ctrl #(
   parameter int REG_W    = 5,
   parameter int LOAD_LAT = 1,
   parameter int CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [REG_W-1:0] id_rs_i,
   input  logic [REG_W-1:0] id_rt_i,
   input  logic             id_use_rt_i,
   input  logic [REG_W-1:0] ex_rs_i,
   input  logic [REG_W-1:0] ex_rt_i,
   input  logic [REG_W-1:0] ex_rd_i,
   input  logic             ex_memrd_i,
   input  logic [1:0]       ex_alusrcb_i,
   input  logic [REG_W-1:0] mem_rd_i,
   input  logic             mem_regwr_i,
   input  logic [REG_W-1:0] wr_rd_i,
   input  logic             wr_regwr_i,
   input  logic             flush_i,
   input  logic             cnt_clr_i,
   output logic [1:0]       alusrca_o,
   output logic [1:0]       alusrcb_o,
   output logic             stall_if_o,
   output logic             bubble_ex_o,
   output logic [CNT_W-1:0] stall_cnt_o
);

   typedef enum logic [0:0] {RUN = 1'b0, STALL = 1'b1} state_t;

   localparam logic [3:0]       REM_INIT = 4'(LOAD_LAT - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   state_t           state_q, state_d;
   logic [3:0]       rem_q, rem_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic mem_a_s, wr_a_s, mem_b_s, wr_b_s, hz_s;

   // Forwarding match terms; register 0 is hard-wired and never forwarded
   always_comb begin
      mem_a_s = mem_regwr_i && (mem_rd_i != '0) && (mem_rd_i == ex_rs_i);
      wr_a_s  = wr_regwr_i  && (wr_rd_i  != '0) && (wr_rd_i  == ex_rs_i);
      mem_b_s = mem_regwr_i && (mem_rd_i != '0) && (mem_rd_i == ex_rt_i);
      wr_b_s  = wr_regwr_i  && (wr_rd_i  != '0) && (wr_rd_i  == ex_rt_i);
      hz_s    = ex_memrd_i && (ex_rd_i != '0) &&
                ((ex_rd_i == id_rs_i) || (id_use_rt_i && (ex_rd_i == id_rt_i)));
   end

   // Operand source selects
   always_comb begin
      alusrca_o = 2'd0;
      alusrcb_o = ex_alusrcb_i;
      if (mem_a_s) begin
         alusrca_o = 2'd1;
      end else if (wr_a_s) begin
         alusrca_o = 2'd2;
      end else begin
         alusrca_o = 2'd0;
      end
      if (mem_b_s) begin
         alusrcb_o = 2'd2;
      end else if (wr_b_s) begin
         alusrcb_o = 2'd3;
      end else begin
         alusrcb_o = ex_alusrcb_i;
      end
   end

   // Stall FSM next state and stall/bubble outputs; flush overrides everything
   always_comb begin
      state_d     = state_q;
      rem_d       = rem_q;
      stall_if_o  = 1'b0;
      bubble_ex_o = 1'b0;
      if (flush_i) begin
         bubble_ex_o = 1'b1;
         state_d     = RUN;
         rem_d       = 4'd0;
      end else begin
         case (state_q)
            RUN: begin
               if (hz_s) begin
                  stall_if_o  = 1'b1;
                  bubble_ex_o = 1'b1;
                  if (LOAD_LAT == 1) begin
                     state_d = RUN;
                     rem_d   = 4'd0;
                  end else begin
                     state_d = STALL;
                     rem_d   = REM_INIT;
                  end
               end else begin
                  state_d = RUN;
               end
            end
            STALL: begin
               stall_if_o  = 1'b1;
               bubble_ex_o = 1'b1;
               rem_d       = rem_q - 4'd1;
               if (rem_q == 4'd1) begin
                  state_d = RUN;
               end else begin
                  state_d = STALL;
               end
            end
            default: begin
               state_d = RUN;
               rem_d   = 4'd0;
            end
         endcase
      end
   end

   // Saturating stall-cycle counter; clear takes precedence
   always_comb begin
      cnt_d = cnt_q;
      if (cnt_clr_i) begin
         cnt_d = '0;
      end else if (stall_if_o && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // State, remaining-stall and counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RUN;
         rem_q   <= 4'd0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         cnt_q   <= cnt_d;
      end
   end

   assign stall_cnt_o = cnt_q;

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Directed scoreboard bench for hazard_forward_ctrl (LOAD_LAT=3, CNT_W=4).
module tb_hazard_forward_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wr_rd;
   logic       id_use_rt, ex_memrd, mem_regwr, wr_regwr, flush, cnt_clr;
   logic [1:0] ex_alusrcb, alusrca, alusrcb;
   logic       stall_if, bubble_ex;
   logic [3:0] stall_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      string      tag;
      logic [1:0] a;
      logic [1:0] b;
      logic       st;
      logic       bub;
      logic [3:0] cnt;
   } exp_t;

   exp_t sb[$];

   hazard_forward_ctrl #(.REG_W(5), .LOAD_LAT(3), .CNT_W(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .id_rs_i(id_rs), .id_rt_i(id_rt), .id_use_rt_i(id_use_rt),
      .ex_rs_i(ex_rs), .ex_rt_i(ex_rt), .ex_rd_i(ex_rd),
      .ex_memrd_i(ex_memrd), .ex_alusrcb_i(ex_alusrcb),
      .mem_rd_i(mem_rd), .mem_regwr_i(mem_regwr),
      .wr_rd_i(wr_rd), .wr_regwr_i(wr_regwr),
      .flush_i(flush), .cnt_clr_i(cnt_clr),
      .alusrca_o(alusrca), .alusrcb_o(alusrcb),
      .stall_if_o(stall_if), .bubble_ex_o(bubble_ex),
      .stall_cnt_o(stall_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: timeout reached, observed running, expected finish");
      $fatal(1, "watchdog");
   end

   task automatic cmp(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input string tag, input logic [1:0] a, input logic [1:0] b,
                       input logic st, input logic bub, input logic [3:0] cnt);
      exp_t e;
      e.tag = tag; e.a = a; e.b = b; e.st = st; e.bub = bub; e.cnt = cnt;
      sb.push_back(e);
   endtask

   // sample combinational outputs mid-cycle, then advance past the next rising edge
   task automatic chk();
      exp_t e;
      @(negedge clk);
      n_tests++;
      assert (sb.size() > 0) else begin
         n_fail++;
         $error("FAIL scoreboard_empty: observed 0 entries expected >0");
      end
      if (sb.size() > 0) begin
         e = sb.pop_front();
         cmp({e.tag, ".alusrca"},   {2'b00, alusrca},   {2'b00, e.a});
         cmp({e.tag, ".alusrcb"},   {2'b00, alusrcb},   {2'b00, e.b});
         cmp({e.tag, ".stall_if"},  {3'b000, stall_if},  {3'b000, e.st});
         cmp({e.tag, ".bubble_ex"}, {3'b000, bubble_ex}, {3'b000, e.bub});
         cmp({e.tag, ".stall_cnt"}, stall_cnt, e.cnt);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      id_rs = 5'd0; id_rt = 5'd0; id_use_rt = 1'b0;
      ex_rs = 5'd0; ex_rt = 5'd0; ex_rd = 5'd0; ex_memrd = 1'b0; ex_alusrcb = 2'd0;
      mem_rd = 5'd0; mem_regwr = 1'b0; wr_rd = 5'd0; wr_regwr = 1'b0;
      flush = 1'b0; cnt_clr = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      push("reset", 2'd0, 2'd0, 1'b0, 1'b0, 4'd0); chk();
      rst_n = 1'b1;

      // forwarding
      ex_rs = 5'd3; mem_rd = 5'd3; mem_regwr = 1'b1; wr_rd = 5'd3; wr_regwr = 1'b1;
      push("fwdA_mem_prio", 2'd1, 2'd0, 1'b0, 1'b0, 4'd0); chk();
      mem_regwr = 1'b0;
      push("fwdA_wb", 2'd2, 2'd0, 1'b0, 1'b0, 4'd0); chk();
      wr_regwr = 1'b0;
      push("fwdA_none", 2'd0, 2'd0, 1'b0, 1'b0, 4'd0); chk();
      ex_rs = 5'd0; ex_rt = 5'd0; mem_rd = 5'd0; mem_regwr = 1'b1; ex_alusrcb = 2'd1;
      push("fwdB_r0", 2'd0, 2'd1, 1'b0, 1'b0, 4'd0); chk();
      ex_rt = 5'd9; mem_rd = 5'd9; wr_rd = 5'd9; wr_regwr = 1'b1;
      push("fwdB_mem_prio", 2'd0, 2'd2, 1'b0, 1'b0, 4'd0); chk();
      mem_regwr = 1'b0;
      push("fwdB_wb", 2'd0, 2'd3, 1'b0, 1'b0, 4'd0); chk();
      ex_rt = 5'd0; mem_rd = 5'd0; wr_rd = 5'd0; wr_regwr = 1'b0; ex_alusrcb = 2'd0;

      // Rt hazard only when id_use_rt
      ex_memrd = 1'b1; ex_rd = 5'd7; id_rt = 5'd7; id_use_rt = 1'b0;
      push("rt_unused", 2'd0, 2'd0, 1'b0, 1'b0, 4'd0); chk();
      id_use_rt = 1'b1;
      push("rt_used", 2'd0, 2'd0, 1'b1, 1'b1, 4'd0); chk();
      ex_memrd = 1'b0; id_use_rt = 1'b0; id_rt = 5'd0; ex_rd = 5'd0;
      push("rt_stall2", 2'd0, 2'd0, 1'b1, 1'b1, 4'd1); chk();
      push("rt_stall3", 2'd0, 2'd0, 1'b1, 1'b1, 4'd2); chk();
      push("rt_done", 2'd0, 2'd0, 1'b0, 1'b0, 4'd3); chk();

      // Rs hazard, single-cycle trigger, three stall cycles
      ex_memrd = 1'b1; ex_rd = 5'd5; id_rs = 5'd5;
      push("rs_stall1", 2'd0, 2'd0, 1'b1, 1'b1, 4'd3); chk();
      ex_memrd = 1'b0; ex_rd = 5'd0; id_rs = 5'd0;
      push("rs_stall2", 2'd0, 2'd0, 1'b1, 1'b1, 4'd4); chk();
      push("rs_stall3", 2'd0, 2'd0, 1'b1, 1'b1, 4'd5); chk();
      push("rs_done", 2'd0, 2'd0, 1'b0, 1'b0, 4'd6); chk();

      // flush in second stall cycle
      ex_memrd = 1'b1; ex_rd = 5'd5; id_rs = 5'd5;
      push("fl_stall1", 2'd0, 2'd0, 1'b1, 1'b1, 4'd6); chk();
      ex_memrd = 1'b0; ex_rd = 5'd0; id_rs = 5'd0; flush = 1'b1;
      push("fl_flush", 2'd0, 2'd0, 1'b0, 1'b1, 4'd7); chk();
      flush = 1'b0;
      push("fl_run", 2'd0, 2'd0, 1'b0, 1'b0, 4'd7); chk();

      // flush beats hazard
      ex_memrd = 1'b1; ex_rd = 5'd5; id_rs = 5'd5; flush = 1'b1;
      push("fl_over_hz", 2'd0, 2'd0, 1'b0, 1'b1, 4'd7); chk();
      ex_memrd = 1'b0; flush = 1'b0;
      push("fl_after", 2'd0, 2'd0, 1'b0, 1'b0, 4'd7); chk();

      // continuous hazard: counter saturates at 15
      ex_memrd = 1'b1;
      for (int i = 0; i < 10; i++) begin
         push("sat_loop", 2'd0, 2'd0, 1'b1, 1'b1, (i > 8) ? 4'd15 : 4'(7 + i));
         chk();
      end
      ex_memrd = 1'b0; cnt_clr = 1'b1;
      push("sat_clr", 2'd0, 2'd0, 1'b1, 1'b1, 4'd15); chk();
      cnt_clr = 1'b0;
      push("after_clr", 2'd0, 2'd0, 1'b1, 1'b1, 4'd0); chk();

      // reset asserted mid-STALL
      ex_memrd = 1'b1;
      push("rst_stall1", 2'd0, 2'd0, 1'b1, 1'b1, 4'd1); chk();
      ex_memrd = 1'b0; ex_rd = 5'd0; id_rs = 5'd0;
      push("rst_stall2", 2'd0, 2'd0, 1'b1, 1'b1, 4'd2); chk();
      rst_n = 1'b0;
      #1;
      push("rst_mid", 2'd0, 2'd0, 1'b0, 1'b0, 4'd0); chk();
      rst_n = 1'b1;
      push("rst_idle", 2'd0, 2'd0, 1'b0, 1'b0, 4'd0); chk();

      n_tests++;
      assert (sb.size() == 0) else begin
         n_fail++;
         $error("FAIL scoreboard_drain: observed %0d entries expected 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
